cdb_result_arbiter: RTL and testbench

//   Shares one 40-bit result bus ({tag[7:0], data[31:0]}) between the add, mult and load

---
 rtl/cdb_pkg.sv | 31 +++
 rtl/cdb_result_arbiter_rr_pick.sv | 32 +++
 rtl/cdb_result_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_result_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and constants for the completion-bus result arbiter.
// Packet layout is {tag, data}; EXC_PAT in the data field marks a faulting result.
package cdb_pkg;

    localparam int N_REQ  = 3;
    localparam int TAG_W  = 8;
    localparam int DATA_W = 32;
    localparam int PKT_W  = TAG_W + DATA_W;
    localparam int IDX_W  = 2;

    localparam logic [DATA_W-1:0] EXC_PAT = 32'hFFFF_FFFF;

    localparam logic [IDX_W-1:0] REQ_ADD  = 2'd0;
    localparam logic [IDX_W-1:0] REQ_MULT = 2'd1;
    localparam logic [IDX_W-1:0] REQ_LOAD = 2'd2;

    // Base tags of each unit's reservation stations; 8'h00 is still a legal tag.
    localparam logic [TAG_W-1:0] TAG_ADD_BASE  = 8'h00;
    localparam logic [TAG_W-1:0] TAG_MULT_BASE = 8'h40;
    localparam logic [TAG_W-1:0] TAG_LOAD_BASE = 8'h80;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_pkt_t;

    function automatic logic is_exc(input logic [DATA_W-1:0] d);
        return d == EXC_PAT;
    endfunction

endpackage

// File: rtl/cdb_result_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first valid bit at or above i_ptr, wrapping mod N.
module rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] i_valid,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    int cand;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        cand     = 0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = (int'(i_ptr) + off) % N;
            if (i_valid[cand]) begin
                o_onehot       = '0;
                o_onehot[cand] = 1'b1;
                o_idx          = W'(cand);
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_result_arbiter.sv
// Round-robin arbiter driving one registered result slot onto the completion bus.
// Define CDB_ARB_EXC_PRIO_EN to let exception results (data == EXC_PAT) jump the queue.
module cdb_result_arbiter
    import cdb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*PKT_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   flush,
    output logic                   cdb_valid,
    output logic [PKT_W-1:0]       cdb_data,
    input  logic                   cdb_ready,
    output logic                   cdb_exc,
    output logic [IDX_W-1:0]       cdb_src
);

    cdb_pkt_t         r_slot;
    logic             r_valid;
    logic [IDX_W-1:0] r_src;
    logic [IDX_W-1:0] r_ptr;

    cdb_pkt_t         w_pkt [N_REQ];
    logic [N_REQ-1:0] w_rr_onehot;
    logic [IDX_W-1:0] w_rr_idx;
    logic             w_rr_any;
    logic [N_REQ-1:0] w_gnt_onehot;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_gnt_any;
    logic             w_slot_free;
    logic             w_grant_en;
    logic             w_take;
    logic [IDX_W-1:0] w_ptr_next;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_pkt[gi] = req_data[gi*PKT_W +: PKT_W];
    end

    rr_pick #(.N(N_REQ), .W(IDX_W)) u_pick (
        .i_valid  (req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_rr_onehot),
        .o_idx    (w_rr_idx),
        .o_any    (w_rr_any)
    );

`ifdef CDB_ARB_EXC_PRIO_EN
    logic [N_REQ-1:0] w_req_exc;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_exc
        assign w_req_exc[gi] = req_valid[gi] && is_exc(w_pkt[gi].data);
    end

    // Lowest-index exception requester overrides the round-robin choice.
    always_comb begin
        w_gnt_onehot = w_rr_onehot;
        w_gnt_idx    = w_rr_idx;
        w_gnt_any    = w_rr_any;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req_exc[i]) begin
                w_gnt_onehot    = '0;
                w_gnt_onehot[i] = 1'b1;
                w_gnt_idx       = IDX_W'(i);
                w_gnt_any       = 1'b1;
            end
        end
    end
`else
    assign w_gnt_onehot = w_rr_onehot;
    assign w_gnt_idx    = w_rr_idx;
    assign w_gnt_any    = w_rr_any;
`endif

    assign w_slot_free = !r_valid || cdb_ready;
    assign w_grant_en  = w_slot_free && !flush && !rst;
    assign w_take      = w_grant_en && w_gnt_any;
    assign req_ready   = w_grant_en ? w_gnt_onehot : '0;
    assign w_ptr_next  = (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_slot  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_slot  <= '0;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_slot  <= w_pkt[w_gnt_idx];
            r_src   <= w_gnt_idx;
            r_ptr   <= w_ptr_next;
        end else if (cdb_ready) begin
            r_valid <= 1'b0;
            r_slot  <= '0;
        end
    end

    assign cdb_valid = r_valid;
    assign cdb_data  = r_slot;
    assign cdb_src   = r_src;
    assign cdb_exc   = r_valid && is_exc(r_slot.data);

endmodule

// File: tb/tb_cdb_result_arbiter.sv
// Table-driven bench for cdb_result_arbiter with a packet scoreboard.
// Exception-priority expectations follow CDB_ARB_EXC_PRIO_EN when defined.
module tb_cdb_result_arbiter;

    localparam logic [31:0] EXC = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_valid;
    logic [119:0] req_data;
    logic [2:0]   req_ready;
    logic         flush;
    logic         cdb_valid;
    logic [39:0]  cdb_data;
    logic         cdb_ready;
    logic         cdb_exc;
    logic [1:0]   cdb_src;

    logic [39:0]  pkt [3];
    logic [39:0]  sb_q [$];
    int           checks = 0;
    int           errors = 0;
    int           step_no = 0;

    typedef struct {
        logic [2:0] rv;
        logic       rdy;
        logic       fl;
        logic [2:0] e_ready;
        logic       e_valid;
        logic [1:0] e_src;
    } vec_t;

    vec_t tbl [22];

    always #5 clk = ~clk;

    assign req_data = {pkt[2], pkt[1], pkt[0]};

    cdb_result_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_ready (cdb_ready),
        .cdb_exc   (cdb_exc),
        .cdb_src   (cdb_src)
    );

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, step_no, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] rv, input logic rdy, input logic fl,
                        input logic [2:0] er, input logic ev, input logic [1:0] es);
        logic [39:0] exp_pkt;
        rst       = r;
        req_valid = rv;
        cdb_ready = rdy;
        flush     = fl;
        @(negedge clk);
        step_no++;
        chk("req_ready", 40'(req_ready), 40'(er));
        chk("cdb_valid", 40'(cdb_valid), 40'(ev));
        if (ev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty step=%0d actual=%h expected=queued packet", step_no, cdb_data);
            end else begin
                exp_pkt = sb_q[0];
                chk("cdb_data", cdb_data, exp_pkt);
                chk("cdb_src", 40'(cdb_src), 40'(es));
                chk("cdb_exc", 40'(cdb_exc), 40'(exp_pkt[31:0] == EXC));
                if (rdy || fl || r) void'(sb_q.pop_front());
            end
        end else begin
            chk("cdb_data_idle", cdb_data, 40'h0);
            chk("cdb_exc_idle", 40'(cdb_exc), 40'h0);
        end
        for (int i = 0; i < 3; i++) begin
            if (er[i]) sb_q.push_back(pkt[i]);
        end
        $display("step %0d rst=%b rv=%b rdy=%b fl=%b req_ready=%b cdb_valid=%b src=%0d data=%h exc=%b",
                 step_no, r, rv, rdy, fl, req_ready, cdb_valid, cdb_src, cdb_data, cdb_exc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        pkt[0] = 40'h01_0000_0005;
        pkt[1] = 40'h02_0000_0077;
        pkt[2] = 40'h00_1234_5678;

        //          rv      rdy   fl    e_ready e_valid e_src
        tbl[0]  = '{3'b001, 1'b1, 1'b0, 3'b001, 1'b0, 2'd0};
        tbl[1]  = '{3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0};
        tbl[2]  = '{3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0};
        tbl[3]  = '{3'b111, 1'b1, 1'b0, 3'b010, 1'b0, 2'd0};
        tbl[4]  = '{3'b111, 1'b1, 1'b0, 3'b100, 1'b1, 2'd1};
        tbl[5]  = '{3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 2'd2};
        tbl[6]  = '{3'b111, 1'b1, 1'b0, 3'b010, 1'b1, 2'd0};
        tbl[7]  = '{3'b111, 1'b1, 1'b0, 3'b100, 1'b1, 2'd1};
        tbl[8]  = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[9]  = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[10] = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[11] = '{3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 2'd2};
        tbl[12] = '{3'b100, 1'b1, 1'b0, 3'b100, 1'b1, 2'd0};
        tbl[13] = '{3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 2'd2};
        tbl[14] = '{3'b001, 1'b1, 1'b1, 3'b000, 1'b1, 2'd1};
        tbl[15] = '{3'b001, 1'b1, 1'b0, 3'b001, 1'b0, 2'd0};
        tbl[16] = '{3'b101, 1'b1, 1'b0, 3'b100, 1'b1, 2'd0};
        tbl[17] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[18] = '{3'b011, 1'b0, 1'b1, 3'b000, 1'b1, 2'd2};
        tbl[19] = '{3'b011, 1'b0, 1'b0, 3'b001, 1'b0, 2'd0};
        tbl[20] = '{3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0};
        tbl[21] = '{3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0};

        // Reset with every requester asking: nothing may be granted.
        step(1'b1, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
        step(1'b1, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
        chk("reset_src", 40'(cdb_src), 40'h0);

        for (int i = 0; i < 22; i++)
            step(1'b0, tbl[i].rv, tbl[i].rdy, tbl[i].fl, tbl[i].e_ready, tbl[i].e_valid, tbl[i].e_src);

        // Mult exception result, flushed on the following cycle.
        pkt[1] = {8'h41, EXC};
        step(1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 2'd0);
        step(1'b0, 3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 2'd1);
        step(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
        pkt[1] = 40'h02_0000_0077;

        // Reset (with flush) while the slot is full; next grant scans from index 0.
        step(1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b0, 2'd0);
        step(1'b1, 3'b111, 1'b1, 1'b1, 3'b000, 1'b1, 2'd1);
        step(1'b0, 3'b111, 1'b1, 1'b0, 3'b001, 1'b0, 2'd0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);

        // rr_ptr=0, add normal + load exception.
        step(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
        pkt[2] = {8'h80, EXC};
`ifdef CDB_ARB_EXC_PRIO_EN
        step(1'b0, 3'b101, 1'b1, 1'b0, 3'b100, 1'b0, 2'd0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2);
`else
        step(1'b0, 3'b101, 1'b1, 1'b0, 3'b001, 1'b0, 2'd0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0);
`endif
        step(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);

        chk("scoreboard_drained", 40'(sb_q.size()), 40'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
